// File: rtl/mini_mips_multicycle.sv
// mini_mips_multicycle: multi-cycle Mini-MIPS core with one shared instruction/data
// memory port. A single FSM sequences fetch, decode, execute, memory and write-back.
// Unsupported or misaligned operations park the core in HALT until reset.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   mem_req/mem_we      request strobe (held until mem_ack) and write select
//   mem_addr/mem_wdata  word-aligned byte address and store data
//   mem_rdata/mem_ack   read data and completion, both sampled in the ack cycle
//   pc                  current program counter
//   retire              pulse in the final cycle of each completed instruction
//   instret             retired-instruction counter (wraps)
//   halted              high while the core sits in HALT
module mini_mips_multicycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted
);

  localparam int IW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_RST    = 3'd7
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q, instret_q;
  logic [31:0] ir_q, a_q, b_q, imm_q, aluout_q, mdr_q;
  logic [31:0] regs_q [REG_COUNT];
  logic [31:0] alu_d;

  logic [5:0]    opcode, funct;
  logic [IW-1:0] rs_idx, rt_idx, rd_idx;

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign rs_idx = ir_q[21 +: IW];
  assign rt_idx = ir_q[16 +: IW];
  assign rd_idx = ir_q[11 +: IW];

  function automatic logic decode_ok(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_R)
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
             (fn == FN_OR)  || (fn == FN_SLT);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)  || (op == OP_J)  || (op == OP_HALT);
  endfunction

  // R-type uses funct; every other user of the ALU (ADDI, LW/SW address) is A+IMM.
  always_comb begin
    alu_d = a_q + imm_q;
    if (opcode == OP_R) begin
      unique case (funct)
        FN_ADD:  alu_d = a_q + b_q;
        FN_SUB:  alu_d = a_q - b_q;
        FN_AND:  alu_d = a_q & b_q;
        FN_OR:   alu_d = a_q | b_q;
        FN_SLT:  alu_d = {31'd0, ($signed(a_q) < $signed(b_q))};
        default: alu_d = 32'd0;
      endcase
    end
  end

  // Memory port and retire decode straight from state; reset forces them idle
  // so a stale state never leaks a request during the reset cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    retire    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_we   = (opcode == OP_SW);
          mem_addr = aluout_q;
          if (opcode == OP_SW) mem_wdata = b_q;
          retire   = (opcode == OP_SW) && mem_ack;
        end
        S_EXEC:  retire = (opcode == OP_BEQ) || (opcode == OP_J);
        S_WB:    retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  assign pc      = reset ? RESET_PC : pc_q;
  assign instret = reset ? 32'd0 : instret_q;
  assign halted  = !reset && (state_q == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RST;
      pc_q      <= RESET_PC;
      instret_q <= 32'd0;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 32'd0;
    end else begin
      if (retire) instret_q <= instret_q + 32'd1;
      unique case (state_q)
        S_RST: state_q <= S_FETCH;
        S_FETCH: if (mem_ack) begin
          ir_q    <= mem_rdata;
          pc_q    <= pc_q + 32'd4;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          a_q     <= regs_q[rs_idx];
          b_q     <= regs_q[rt_idx];
          imm_q   <= {{16{ir_q[15]}}, ir_q[15:0]};
          state_q <= decode_ok(opcode, funct) ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          unique case (opcode)
            OP_R, OP_ADDI: begin
              aluout_q <= alu_d;
              state_q  <= S_WB;
            end
            OP_LW, OP_SW: begin
              aluout_q <= alu_d;
              // Misaligned address halts before any request goes out.
              state_q  <= (alu_d[1:0] != 2'b00) ? S_HALT : S_MEM;
            end
            OP_BEQ: begin
              // pc_q already holds pc+4 from FETCH.
              if (a_q == b_q) pc_q <= pc_q + {imm_q[29:0], 2'b00};
              state_q <= S_FETCH;
            end
            OP_J: begin
              pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
              state_q <= S_FETCH;
            end
            default: state_q <= S_HALT;
          endcase
        end
        S_MEM: if (mem_ack) begin
          if (opcode == OP_SW) begin
            state_q <= S_FETCH;
          end else begin
            mdr_q   <= mem_rdata;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          // Index 0 is never written, so r0 reads as zero forever.
          if (opcode == OP_R) begin
            if (rd_idx != '0) regs_q[rd_idx] <= aluout_q;
          end else if (opcode == OP_ADDI) begin
            if (rt_idx != '0) regs_q[rt_idx] <= aluout_q;
          end else begin
            if (rt_idx != '0) regs_q[rt_idx] <= mdr_q;
          end
          state_q <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_mips_multicycle.sv
// Directed bench for mini_mips_multicycle: a behavioural memory with programmable
// wait states answers the single memory port; results are read back from memory.
module tb_mini_mips_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc, instret;
  logic        retire, halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  int   wait_n    = 0;
  int   wcnt      = 0;
  logic ack_force = 1'b1;

  int   cyc = 0, n_ret = 0, n_ack = 0, sw8_run = 0;
  int   start_cyc = -1, ret4_cyc = -1;
  logic prev_ret = 1'b0;
  logic patch_en = 1'b1;
  logic [31:0] pc_log [$];

  mini_mips_multicycle dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc        (pc),
    .retire    (retire),
    .instret   (instret),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responds on the falling edge so the DUT samples stable ack/rdata.
  always @(negedge clk) begin
    if (ack_force) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'd0;
      wcnt      = 0;
    end else if (mem_req) begin
      if (wcnt >= wait_n) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_we ? 32'd0 : mem[mem_addr[9:2]];
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        wcnt      = 0;
        n_ack++;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  // Monitor runs after the memory update has settled into retire.
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (prev_ret) pc_log.push_back(pc);
    prev_ret = retire;
    if (retire) begin
      n_ret++;
      if (n_ret == 4) ret4_cyc = cyc;
      // After observing the BEQ self-loop twice, turn it into J 0x40.
      if (patch_en && n_ret == 11) mem[9] = {6'h02, 26'h40};
    end
    if (mem_req && !reset && start_cyc < 0) start_cyc = cyc;
    if (mem_req && mem_we && mem_addr == 32'h8 && mem_wdata == 32'h2) sw8_run++;
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_ret(input int n, input int budget, input string tag);
    int k = 0;
    while (n_ret < n && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(n_ret >= n), 32'd1);
  endtask

  task automatic wait_halt(input int budget, input string tag);
    int k = 0;
    while (!halted && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(halted), 32'd1);
  endtask

  logic [31:0] exp_pc [12];
  int ack_base;

  initial begin
    exp_pc = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
               32'h1C, 32'h20, 32'h24, 32'h24, 32'h24, 32'h100};
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0]  = ei(6'h08, 5'd0, 5'd1, 16'd5);        // ADDI r1,r0,5
    mem[1]  = ei(6'h08, 5'd0, 5'd2, 16'hFFFD);     // ADDI r2,r0,-3
    mem[2]  = er(5'd1, 5'd2, 5'd3, 6'h20);         // ADD  r3,r1,r2
    mem[3]  = er(5'd2, 5'd1, 5'd4, 6'h2A);         // SLT  r4,r2,r1
    mem[4]  = ei(6'h2B, 5'd0, 5'd3, 16'h0008);     // SW   r3,8(r0)
    mem[5]  = ei(6'h23, 5'd0, 5'd5, 16'h0008);     // LW   r5,8(r0)
    mem[6]  = ei(6'h2B, 5'd0, 5'd5, 16'h0204);     // SW   r5,0x204(r0)
    mem[7]  = ei(6'h2B, 5'd0, 5'd4, 16'h0208);     // SW   r4,0x208(r0)
    mem[8]  = ei(6'h04, 5'd1, 5'd2, 16'd5);        // BEQ  r1,r2,+5 (not taken)
    mem[9]  = ei(6'h04, 5'd1, 5'd1, 16'hFFFF);     // BEQ  r1,r1,-1 (self loop)
    mem[64] = ei(6'h23, 5'd0, 5'd1, 16'h0002);     // LW   r1,2(r0) misaligned
    for (int i = 128; i < 134; i++) mem[i] = 32'hFFFF_FFFF;

    // Reset held three cycles with ack asserted
    repeat (3) tick();
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_pc", pc, 32'd0);
    check_eq("rst_instret", instret, 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    reset     = 1'b0;
    ack_force = 1'b0;
    #1;
    check_eq("rst_state_req", 32'(mem_req), 32'd0);
    tick();
    check_eq("req_rise", 32'(mem_req), 32'd1);
    check_eq("fetch_addr", mem_addr, 32'd0);
    check_eq("pc_after_rst", pc, 32'd0);

    // Four ALU instructions, zero wait
    wait_ret(4, 100, "ret4_reached");
    check_eq("alu_cycles", 32'(ret4_cyc - start_cyc + 1), 32'd16);
    wait_n = 3;
    tick();
    check_eq("instret4", instret, 32'd4);

    // Stores/loads with wait states, branches and jump, then misaligned halt
    wait_ret(12, 400, "ret12_reached");
    ack_base = n_ack;
    repeat (15) tick();
    check_eq("sw_held", 32'(sw8_run), 32'd4);
    check_eq("r3_stored", mem[2], 32'd2);
    check_eq("r5_loaded", mem[129], 32'd2);
    check_eq("r4_slt", mem[130], 32'd1);
    check_eq("pclog_n", 32'(pc_log.size()), 32'd12);
    if (pc_log.size() >= 12)
      for (int i = 0; i < 12; i++) check_eq($sformatf("pc_after_ret%0d", i + 1), pc_log[i], exp_pc[i]);
    check_eq("mis_halted", 32'(halted), 32'd1);
    check_eq("mis_no_req", 32'(n_ack - ack_base), 32'd1);
    check_eq("mis_pc", pc, 32'h104);
    check_eq("mis_instret", instret, 32'd12);
    check_eq("halt_req", 32'(mem_req), 32'd0);
    check_eq("halt_ret", 32'(n_ret), 32'd12);

    // Reset in the middle of a store with ack held during reset
    patch_en = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    mem[0]   = ei(6'h08, 5'd0, 5'd1, 16'd9);       // ADDI r1,r0,9
    mem[1]   = ei(6'h2B, 5'd0, 5'd1, 16'h0214);    // SW   r1,0x214(r0)
    mem[131] = 32'hFFFF_FFFF;
    mem[132] = 32'h0000_1234;
    mem[133] = 32'h0000_DEAD;
    wait_n = 10;
    reset  = 1'b0;
    begin
      int k = 0;
      while (!(mem_req && mem_we) && k < 200) begin
        tick();
        k++;
      end
    end
    check_eq("mid_mem_seen", 32'(mem_req && mem_we), 32'd1);
    check_eq("mid_instret", instret, 32'd1);
    reset     = 1'b1;
    ack_force = 1'b1;
    mem[0] = ei(6'h08, 5'd0, 5'd0, 16'd7);          // ADDI r0,r0,7
    mem[1] = ei(6'h2B, 5'd0, 5'd0, 16'h020C);       // SW   r0,0x20C(r0)
    mem[2] = ei(6'h2B, 5'd0, 5'd1, 16'h0210);       // SW   r1,0x210(r0)
    mem[3] = 32'hFC00_0000;                         // HALT
    tick();
    tick();
    check_eq("rst2_req", 32'(mem_req), 32'd0);
    check_eq("rst2_instret", instret, 32'd0);
    check_eq("rst2_pc", pc, 32'd0);
    check_eq("rst2_halted", 32'(halted), 32'd0);
    reset     = 1'b0;
    ack_force = 1'b0;
    wait_n    = 0;
    wait_halt(100, "op3f_halted");
    check_eq("op3f_instret", instret, 32'd3);
    check_eq("r0_zero", mem[131], 32'd0);
    check_eq("r1_cleared", mem[132], 32'd0);
    check_eq("aborted_sw", mem[133], 32'h0000_DEAD);
    check_eq("op3f_pc", pc, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
